// File: rtl/msrv32_instr_fetch_unit_if.sv
// Bus bundle for the msrv32 fetch unit: redirect input, imem request/response
// channels and the decode-facing instruction channel.
interface msrv32_instr_fetch_unit_if;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic [31:0] imaddr_out;
  logic        imaddr_valid_out;
  logic        imaddr_ready_in;
  logic [31:0] imdata_in;
  logic        imdata_valid_in;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic        misaligned_out;

  modport master (
    input  redirect_in, redirect_pc_in, imaddr_ready_in, imdata_in, imdata_valid_in,
           instr_ready_in,
    output imaddr_out, imaddr_valid_out, instr_out, instr_pc_out, instr_valid_out,
           misaligned_out
  );

  modport slave (
    output redirect_in, redirect_pc_in, imaddr_ready_in, imdata_in, imdata_valid_in,
           instr_ready_in,
    input  imaddr_out, imaddr_valid_out, instr_out, instr_pc_out, instr_valid_out,
           misaligned_out
  );
endinterface

// File: rtl/msrv32_instr_fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, in-order response
// buffering with PCs, and redirect flushing of stale in-flight fetches.
module msrv32_instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic                      ms_riscv32_mp_clk_in,
  input  logic                      ms_riscv32_mp_rst_in,
  msrv32_instr_fetch_unit_if.master bus
);
  localparam int CW  = $clog2(MAX_OUTST + 1);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int PQW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [1:0] {START, FETCH, FLUSH, HALT} state_t;
  state_t state_reg, state_next;

  logic [31:0]    fetch_pc_reg;
  logic [CW-1:0]  outstanding_reg, outstanding_next, drop_cnt_reg;
  logic           misaligned_reg;

  logic [31:0]    pcq_mem [MAX_OUTST];
  logic [PQW-1:0] pcq_wr_reg, pcq_rd_reg;

  logic [63:0]    fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0] fifo_wr_reg, fifo_rd_reg;
  logic [FAW:0]   fifo_cnt_reg;

  logic redirect, req_valid, accept, resp, push, pop, fifo_nonempty, pc_misaligned;

  function automatic logic [PQW-1:0] pcq_inc(input logic [PQW-1:0] ptr);
    return (ptr == PQW'(MAX_OUTST - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign redirect      = bus.redirect_in && (state_reg != START);
  assign pc_misaligned = (fetch_pc_reg[1:0] != 2'b00);
  assign fifo_nonempty = (fifo_cnt_reg != '0);
  assign accept        = req_valid && bus.imaddr_ready_in;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp          = bus.imdata_valid_in && (outstanding_reg != '0);
  assign push          = resp && !redirect && (state_reg != FLUSH);
  assign pop           = fifo_nonempty && bus.instr_ready_in && !redirect;
  assign outstanding_next = outstanding_reg + CW'(accept) - CW'(resp);

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) state_reg <= START;
    else                       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      START: state_next = FETCH;
      FETCH: if (pc_misaligned) state_next = HALT;
      FLUSH: if (drop_cnt_reg == '0 || (resp && drop_cnt_reg == CW'(1))) state_next = FETCH;
      HALT:  state_next = HALT;
      default: state_next = START;
    endcase
    // A same-cycle accept is already in flight and must be dropped too.
    if (redirect) state_next = (outstanding_next != '0) ? FLUSH : FETCH;
  end

  // Credit rule: every in-flight request must have a guaranteed FIFO slot.
  always_comb begin
    req_valid = 1'b0;
    if (state_reg == FETCH && !pc_misaligned &&
        (32'(outstanding_reg) + 32'(fifo_cnt_reg) < 32'(FIFO_DEPTH)) &&
        (32'(outstanding_reg) < 32'(MAX_OUTST)))
      req_valid = 1'b1;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      misaligned_reg  <= 1'b0;
      pcq_wr_reg      <= '0;
      pcq_rd_reg      <= '0;
      fifo_wr_reg     <= '0;
      fifo_rd_reg     <= '0;
      fifo_cnt_reg    <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      // The PC queue tracks every accepted request, dropped or not.
      if (accept) pcq_wr_reg <= pcq_inc(pcq_wr_reg);
      if (resp)   pcq_rd_reg <= pcq_inc(pcq_rd_reg);
      if (redirect) begin
        fetch_pc_reg   <= bus.redirect_pc_in;
        misaligned_reg <= 1'b0;
        drop_cnt_reg   <= outstanding_next;
        fifo_wr_reg    <= '0;
        fifo_rd_reg    <= '0;
        fifo_cnt_reg   <= '0;
      end else begin
        if (accept) fetch_pc_reg <= fetch_pc_reg + 32'd4;
        if (state_reg == FETCH && pc_misaligned) misaligned_reg <= 1'b1;
        if (state_reg == FLUSH && resp && drop_cnt_reg != '0)
          drop_cnt_reg <= drop_cnt_reg - CW'(1);
        if (push) fifo_wr_reg <= fifo_wr_reg + 1'b1;
        if (pop)  fifo_rd_reg <= fifo_rd_reg + 1'b1;
        fifo_cnt_reg <= fifo_cnt_reg + (FAW + 1)'(push) - (FAW + 1)'(pop);
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (accept) pcq_mem[pcq_wr_reg] <= fetch_pc_reg;
    if (push)   fifo_mem[fifo_wr_reg] <= {pcq_mem[pcq_rd_reg], bus.imdata_in};
  end

  assign bus.imaddr_out       = fetch_pc_reg;
  assign bus.imaddr_valid_out = req_valid;
  assign bus.instr_valid_out  = fifo_nonempty;
  assign bus.instr_out        = fifo_nonempty ? fifo_mem[fifo_rd_reg][31:0]  : 32'h0;
  assign bus.instr_pc_out     = fifo_nonempty ? fifo_mem[fifo_rd_reg][63:32] : 32'h0;
  assign bus.misaligned_out   = misaligned_reg;
endmodule
